// File: rtl/pulse_chk_pkg.sv
// ---------------------------------------------------------------------------
// pulse_chk_pkg
// Shared types and helpers for the pulse_window_checker monitor.
//   chan_state_e : per-channel FSM state (IDLE, HIGH, WAIT_LOW)
//   fail_code_e  : 2-bit failure code reported with fail_stb
//   popcount()   : number of set bits in a strobe vector (up to MAX_CH bits)
// ---------------------------------------------------------------------------
package pulse_chk_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HIGH     = 2'd1,
        WAIT_LOW = 2'd2
    } chan_state_e;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        GUARD = 2'd1,
        SHORT = 2'd2,
        LONG  = 2'd3
    } fail_code_e;

    // Widest strobe vector popcount() accepts; callers zero-extend to this.
    localparam int MAX_CH = 64;
    localparam int POP_W  = $clog2(MAX_CH + 1);

    function automatic logic [POP_W-1:0] popcount(input logic [MAX_CH-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/pulse_chk_chan.sv
// ---------------------------------------------------------------------------
// pulse_chk_chan
// One monitored channel: pulse history, window FSM, high-length counter and
// registered pass/fail strobes.
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   en        in   check enable; low forces IDLE and drops the window
//   pulse     in   monitored pulse
//   guard     in   must stay low while the window is open
//   pass_stb  out  1-cycle pass strobe, one cycle after the deciding sample
//   fail_stb  out  1-cycle fail strobe, one cycle after the deciding sample
//   fail_code out  fail_code_e value, valid with fail_stb
//   busy      out  channel is in HIGH
// ---------------------------------------------------------------------------
module pulse_chk_chan
    import pulse_chk_pkg::*;
#(
    parameter int MIN_HI = 2,
    parameter int MAX_HI = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       pulse,
    input  logic       guard,
    output logic       pass_stb,
    output logic       fail_stb,
    output logic [1:0] fail_code,
    output logic       busy
);

    localparam int LEN_W = $clog2(MAX_HI + 1);
    localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_HI);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_HI);

    chan_state_e      state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             prev_q, prev_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    fail_code_e       code_q, code_d;
    logic             rise;

    assign rise = pulse & ~prev_q;

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        prev_d  = pulse;
        pass_d  = 1'b0;
        fail_d  = 1'b0;
        code_d  = NONE;

        if (!en) begin
            // Window abandoned silently; rises are not looked at.
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rise) begin
                        len_d = LEN_W'(1);
                        if (guard) begin
                            fail_d  = 1'b1;
                            code_d  = GUARD;
                            state_d = WAIT_LOW;
                        end else begin
                            // Enter HIGH even when MAX_HI==1: the next high
                            // sample then trips the LONG check.
                            state_d = HIGH;
                        end
                    end
                end
                HIGH: begin
                    if (guard) begin
                        fail_d  = 1'b1;
                        code_d  = GUARD;
                        state_d = pulse ? WAIT_LOW : IDLE;
                    end else if (!pulse) begin
                        if (len_q < MIN_LEN) begin
                            fail_d = 1'b1;
                            code_d = SHORT;
                        end else begin
                            pass_d = 1'b1;
                        end
                        state_d = IDLE;
                    end else if (len_q == MAX_LEN) begin
                        fail_d  = 1'b1;
                        code_d  = LONG;
                        state_d = WAIT_LOW;
                    end else begin
                        len_d = len_q + LEN_W'(1);
                    end
                end
                WAIT_LOW: begin
                    if (!pulse) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values computed above, independent of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            prev_q  <= 1'b1;  // a pulse already high at reset is not a rise
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            code_q  <= NONE;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            prev_q  <= prev_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            code_q  <= code_d;
        end
    end

    assign pass_stb  = pass_q;
    assign fail_stb  = fail_q;
    assign fail_code = code_q;
    assign busy      = (state_q == HIGH);

endmodule

// File: rtl/pulse_window_checker.sv
// ---------------------------------------------------------------------------
// pulse_window_checker
// Multi-channel pulse-window protocol monitor. Each channel checks that a
// rising pulse stays high for MIN_HI..MAX_HI samples with guard low, and the
// top aggregates pass/fail strobes into saturating counters.
// Optional feature: define PULSE_CHK_STICKY_EN to add clr_sticky/sticky_fail.
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   en          in   global check enable
//   pulse       in   [CH]     monitored pulses
//   guard       in   [CH]     must-stay-low signals
//   clr_sticky  in            clear sticky_fail (PULSE_CHK_STICKY_EN only)
//   sticky_fail out  [CH]     latched fail flags (PULSE_CHK_STICKY_EN only)
//   pass_stb    out  [CH]     1-cycle pass strobes
//   fail_stb    out  [CH]     1-cycle fail strobes
//   fail_code   out  [2*CH]   per-channel codes, 1=GUARD 2=SHORT 3=LONG
//   busy        out  [CH]     channel inside a window
//   pass_cnt    out  [CNT_W]  saturating pass total
//   fail_cnt    out  [CNT_W]  saturating fail total
// CH is limited to pulse_chk_pkg::MAX_CH by the popcount helper.
// ---------------------------------------------------------------------------
module pulse_window_checker
    import pulse_chk_pkg::*;
#(
    parameter int CH     = 4,
    parameter int MIN_HI = 2,
    parameter int MAX_HI = 2,
    parameter int CNT_W  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [CH-1:0]   pulse,
    input  logic [CH-1:0]   guard,
`ifdef PULSE_CHK_STICKY_EN
    input  logic            clr_sticky,
    output logic [CH-1:0]   sticky_fail,
`endif
    output logic [CH-1:0]   pass_stb,
    output logic [CH-1:0]   fail_stb,
    output logic [2*CH-1:0] fail_code,
    output logic [CH-1:0]   busy,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    // Sum width leaves headroom for adding up to CH at once before saturating.
    localparam int SUM_W = CNT_W + $clog2(CH + 1);
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    for (genvar i = 0; i < CH; i++) begin : g_chan
        pulse_chk_chan #(
            .MIN_HI (MIN_HI),
            .MAX_HI (MAX_HI)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .pulse     (pulse[i]),
            .guard     (guard[i]),
            .pass_stb  (pass_stb[i]),
            .fail_stb  (fail_stb[i]),
            .fail_code (fail_code[2*i +: 2]),
            .busy      (busy[i])
        );
    end

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [CH-1:0]    stb);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(cnt) + SUM_W'(popcount(MAX_CH'(stb)));
        return (sum > CNT_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;

    always_comb begin
        pass_cnt_d = sat_add(pass_cnt_q, pass_stb);
        fail_cnt_d = sat_add(fail_cnt_q, fail_stb);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign pass_cnt = pass_cnt_q;
    assign fail_cnt = fail_cnt_q;

`ifdef PULSE_CHK_STICKY_EN
    logic [CH-1:0] sticky_q, sticky_d;

    // The register captures fail_stb, and the output ORs in the live strobe,
    // so the flag shows in the same cycle as fail_stb and a clear arriving
    // with the decision or the strobe cannot win against it.
    always_comb begin
        sticky_d = (sticky_q & ~{CH{clr_sticky}}) | fail_stb;
    end

    always_ff @(posedge clk) begin
        if (rst) sticky_q <= '0;
        else     sticky_q <= sticky_d;
    end

    assign sticky_fail = sticky_q | fail_stb;
`endif

endmodule
